// File: rtl/udp_tx_feeder_if.sv
// udp_tx_feeder_if: user write port and transmit-engine handshake of the UDP/ARP feeder
interface udp_tx_feeder_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       arp_req;
    logic       go;
    logic       arp;
    logic       fifo_en;
    logic [3:0] fifo_data;
    logic       s_en;
    logic       frm_sent;
    logic       ovf;
    logic       tmo;
    modport master (
        output wr_en, wr_data, arp_req, fifo_en, s_en,
        input  wr_ready, go, arp, fifo_data, frm_sent, ovf, tmo
    );
    modport slave (
        input  wr_en, wr_data, arp_req, fifo_en, s_en,
        output wr_ready, go, arp, fifo_data, frm_sent, ovf, tmo
    );
endinterface

// File: rtl/udp_tx_feeder.sv
// udp_tx_feeder: two-bank payload buffer and frame scheduler feeding the UDP/ARP transmit engine
module udp_tx_feeder #(
    parameter int PAYLOAD_BYTES = 18,
    parameter int IFG_CLKS      = 128,
    parameter int START_TMO     = 64
) (
    input  logic s_clk,
    input  logic rst_n,
    udp_tx_feeder_if.slave bus
);
    localparam int PW = $clog2(PAYLOAD_BYTES);
    localparam int NW = $clog2(2*PAYLOAD_BYTES+1);
    localparam int GW = $clog2(IFG_CLKS+1);
    localparam int TW = $clog2(START_TMO);
    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT_ON, ACTIVE} state_t;
    state_t state;
    logic [7:0] mem [2][PAYLOAD_BYTES];
    logic [1:0] full;
    logic wr_bank, rd_bank, arp_pend;
    logic [PW-1:0] wr_ptr;
    logic [NW-1:0] rd_nib;
    logic [GW-1:0] gap;
    logic [TW-1:0] cnt;
    logic wr_acc, last_wr, rel, nib_ok;
    logic [7:0] rd_byte;
    assign bus.wr_ready = ~&full;
    assign wr_acc  = bus.wr_en & bus.wr_ready;
    assign last_wr = wr_acc && wr_ptr == PW'(PAYLOAD_BYTES-1);
    assign rel     = state == ACTIVE && !bus.s_en && !bus.arp;
    assign nib_ok  = !bus.arp && rd_nib < NW'(2*PAYLOAD_BYTES);
    assign rd_byte = mem[rd_bank][rd_nib[NW-1:1]];
    always_ff @(posedge s_clk)
        if (wr_acc) mem[wr_bank][wr_ptr] <= bus.wr_data;
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            full <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            arp_pend <= 1'b0;
            wr_ptr <= '0;
            rd_nib <= '0;
            gap <= '0;
            cnt <= '0;
            bus.go <= 1'b0;
            bus.arp <= 1'b0;
            bus.fifo_data <= 4'h0;
            bus.frm_sent <= 1'b0;
            bus.ovf <= 1'b0;
            bus.tmo <= 1'b0;
        end else begin
            bus.go <= 1'b0;
            bus.frm_sent <= 1'b0;
            bus.tmo <= 1'b0;
            bus.ovf <= bus.wr_en & ~bus.wr_ready;
            // release and fill never hit the same bank: the write side always owns the other one
            full <= (full | {last_wr & wr_bank, last_wr & ~wr_bank}) & ~{rel & rd_bank, rel & ~rd_bank};
            if (wr_acc) begin
                wr_ptr <= last_wr ? '0 : wr_ptr + 1'b1;
                if (last_wr) wr_bank <= ~wr_bank;
            end
            arp_pend <= (state == START && bus.arp) ? 1'b0 : arp_pend | bus.arp_req;
            if (state == ACTIVE && bus.fifo_en) begin
                bus.fifo_data <= nib_ok ? (rd_nib[0] ? rd_byte[7:4] : rd_byte[3:0]) : 4'h0;
                if (nib_ok) rd_nib <= rd_nib + 1'b1;
            end
            case (state)
                IDLE:
                    if (gap != '0) gap <= gap - 1'b1;
                    else if (arp_pend || full[rd_bank]) begin
                        bus.arp <= arp_pend;
                        state <= SETUP;
                    end
                SETUP: begin
                    bus.go <= 1'b1;
                    state <= START;
                end
                START: begin
                    rd_nib <= '0;
                    cnt <= '0;
                    state <= WAIT_ON;
                end
                WAIT_ON:
                    if (bus.s_en) state <= ACTIVE;
                    else if (cnt == TW'(START_TMO-1)) begin
                        bus.tmo <= 1'b1;
                        bus.arp <= 1'b0;
                        state <= IDLE;
                    end else cnt <= cnt + 1'b1;
                ACTIVE:
                    if (!bus.s_en) begin
                        bus.frm_sent <= 1'b1;
                        bus.arp <= 1'b0;
                        gap <= GW'(IFG_CLKS-1);
                        if (!bus.arp) rd_bank <= ~rd_bank;
                        state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_feeder.sv
// tb_udp_tx_feeder: directed checks of the feeder with a hand-driven engine model
module tb_udp_tx_feeder;
    logic s_clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t0;
    bit   found;
    udp_tx_feeder_if bus();
    udp_tx_feeder dut (.s_clk(s_clk), .rst_n(rst_n), .bus(bus));
    always #5 s_clk = ~s_clk;
    always @(posedge s_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        @(negedge s_clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_go(input int bound, output bit f);
        f = 1'b0;
        for (int i = 0; i < bound && !f; i++) begin
            @(negedge s_clk);
            f = bus.go;
        end
    endtask

    task automatic go_active();
        bus.s_en = 1'b1;
        repeat (2) @(negedge s_clk);
    endtask

    task automatic end_frame();
        bus.fifo_en = 1'b0;
        bus.s_en = 1'b0;
        @(negedge s_clk);
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.arp_req = 1'b0;
        bus.fifo_en = 1'b0;
        bus.s_en = 1'b0;
        repeat (3) @(negedge s_clk);
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_go", bus.go, 0);
        chk("rst_arp", bus.arp, 0);
        chk("rst_fifo_data", bus.fifo_data, 0);
        chk("rst_flags", {bus.frm_sent, bus.ovf, bus.tmo}, 0);
        rst_n = 1'b1;
        @(negedge s_clk);

        // basic UDP frame: bytes 0x00..0x11
        for (int i = 0; i < 18; i++) wr(8'(i));
        t0 = cyc;
        wait_go(20, found);
        chk("t1_go_seen", found, 1);
        chk("t1_go_delay", cyc - t0, 2);
        chk("t1_arp", bus.arp, 0);
        go_active();
        bus.fifo_en = 1'b1;
        for (int k = 0; k < 36; k++) begin
            logic [7:0] b;
            @(negedge s_clk);
            b = 8'(k / 2);
            chk($sformatf("t1_nib%0d", k), bus.fifo_data, (k % 2) ? b[7:4] : b[3:0]);
        end
        @(negedge s_clk);
        chk("t1_nib_past_end", bus.fifo_data, 0);
        end_frame();
        chk("t1_frm_sent", bus.frm_sent, 1);
        t0 = cyc;

        // recovery gap: second bank written during the gap
        for (int i = 0; i < 18; i++) wr(8'hA0 + 8'(i));
        chk("t5_frm_sent_pulse", bus.frm_sent, 0);
        wait_go(200, found);
        chk("t5_go_seen", found, 1);
        chk("t5_ifg_go", cyc - t0, 129);
        go_active();
        bus.fifo_en = 1'b1;
        @(negedge s_clk);
        chk("t5_nib0", bus.fifo_data, 4'h0);
        @(negedge s_clk);
        chk("t5_nib1", bus.fifo_data, 4'hA);
        end_frame();
        chk("t5_frm_sent", bus.frm_sent, 1);

        // ARP request and bank-full in the same cycle
        repeat (135) @(negedge s_clk);
        for (int i = 0; i < 17; i++) wr(8'h30 + 8'(i));
        bus.arp_req = 1'b1;
        wr(8'h41);
        bus.arp_req = 1'b0;
        @(negedge s_clk);
        chk("t2_setup_arp", bus.arp, 1);
        chk("t2_setup_go", bus.go, 0);
        @(negedge s_clk);
        chk("t2_start_go", bus.go, 1);
        chk("t2_start_arp", bus.arp, 1);
        go_active();
        bus.fifo_en = 1'b1;
        @(negedge s_clk);
        chk("t2_arp_nib", bus.fifo_data, 0);
        end_frame();
        chk("t2_arp_sent", bus.frm_sent, 1);
        chk("t2_arp_idle", bus.arp, 0);
        t0 = cyc;
        wait_go(200, found);
        chk("t2_udp_go", found, 1);
        chk("t2_udp_gap", cyc - t0, 129);
        chk("t2_udp_arp", bus.arp, 0);
        go_active();
        bus.fifo_en = 1'b1;
        @(negedge s_clk);
        chk("t2_nib0", bus.fifo_data, 4'h0);
        @(negedge s_clk);
        chk("t2_nib1", bus.fifo_data, 4'h3);
        end_frame();
        wait_go(200, found);
        chk("t2_no_more_go", found, 0);

        // overflow: 36 bytes fill both banks, the 37th is dropped
        for (int i = 0; i < 36; i++) begin
            wr(8'h50 + 8'(i));
            if (i == 17) chk("t3_ready_one_full", bus.wr_ready, 1);
        end
        chk("t3_ready_both_full", bus.wr_ready, 0);
        chk("t3_no_ovf_yet", bus.ovf, 0);
        wr(8'hEE);
        chk("t3_ovf", bus.ovf, 1);
        @(negedge s_clk);
        chk("t3_ovf_pulse", bus.ovf, 0);
        chk("t3_still_full", bus.wr_ready, 0);

        // start timeout with s_en held low, then retry
        wait_go(200, found);
        chk("t4_go", found, 1);
        t0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge s_clk);
            found = bus.tmo;
        end
        chk("t4_tmo_seen", found, 1);
        chk("t4_tmo_delay", cyc - t0, 65);
        t0 = cyc;
        wait_go(10, found);
        chk("t4_retry_go", found, 1);
        chk("t4_retry_delay", cyc - t0, 2);

        // reset in the middle of an active frame
        go_active();
        bus.fifo_en = 1'b1;
        repeat (2) @(negedge s_clk);
        chk("t6_nib_before_rst", bus.fifo_data, 4'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_go", bus.go, 0);
        chk("t6_arp", bus.arp, 0);
        chk("t6_fifo_data", bus.fifo_data, 0);
        chk("t6_wr_ready", bus.wr_ready, 1);
        bus.s_en = 1'b0;
        bus.fifo_en = 1'b0;
        @(negedge s_clk);
        rst_n = 1'b1;
        wait_go(100, found);
        chk("t6_discarded", found, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
